// File: rtl/lte_ul_pd_sched_pkg.sv
// Shared definitions for the uplink power-detect scheduler: FSM encoding,
// parameter defaults and the antenna search helper.
package lte_ul_pd_sched_pkg;

  localparam int unsigned NUM_ANT_DEF    = 8;
  localparam int unsigned FRAM_DIV_DEF   = 300;
  localparam int unsigned GUARD_CLK_DEF  = 16;
  // 5 ms at 245.76 MHz
  localparam int unsigned FRAME_5MS_CLKS = 1228800;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_MEAS  = 3'd2,
    ST_GUARD = 3'd3,
    ST_NEXT  = 3'd4
  } pd_state_e;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [3:0] find_ant(input logic [7:0] mask, input int unsigned from);
    logic [3:0] res;
    res = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!res[3] && (i >= from) && mask[i]) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/lte_ul_pd_rd_arb.sv
// Two-port round-robin arbiter for the power-detect RAM read port.
// Grants are combinational; the RAM address is registered.
module lte_ul_pd_rd_arb (
  input  logic       clk_245,
  input  logic       asy_rst_n,
  input  logic       i_rd_req_a,
  input  logic       i_rd_req_b,
  input  logic [7:0] i_rd_addr_a,
  input  logic [7:0] i_rd_addr_b,
  output logic       o_rd_gnt_a,
  output logic       o_rd_gnt_b,
  output logic [7:0] o_ram_raddr
);

  logic last_a;

  // Grants are forced low while reset is asserted so nothing leaks out.
  always_comb begin
    o_rd_gnt_a = asy_rst_n & i_rd_req_a & (~i_rd_req_b | ~last_a);
    o_rd_gnt_b = asy_rst_n & i_rd_req_b & ~o_rd_gnt_a;
  end

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      last_a      <= 1'b0;
      o_ram_raddr <= '0;
    end else if (o_rd_gnt_a) begin
      last_a      <= 1'b1;
      o_ram_raddr <= i_rd_addr_a;
    end else if (o_rd_gnt_b) begin
      last_a      <= 1'b0;
      o_ram_raddr <= i_rd_addr_b;
    end
  end

endmodule

// File: rtl/lte_ul_pd_sched.sv
// Uplink power-detect scheduler: steps the detector across the masked antennas,
// one FRAM_DIV-frame window each, and hosts the RAM read arbiter.
module lte_ul_pd_sched
  import lte_ul_pd_sched_pkg::*;
#(
  parameter int unsigned NUM_ANT   = NUM_ANT_DEF,
  parameter int unsigned FRAM_DIV  = FRAM_DIV_DEF,
  parameter int unsigned GUARD_CLK = GUARD_CLK_DEF
) (
  input  logic       clk_245,
  input  logic       asy_rst_n,
  input  logic       i_fram_hd,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_ant_mask,
  output logic [2:0] o_ant_sel,
  output logic       o_pd_trig,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_seq_end,
  output logic       o_err,
  input  logic       i_rd_req_a,
  input  logic       i_rd_req_b,
  input  logic [7:0] i_rd_addr_a,
  input  logic [7:0] i_rd_addr_b,
  output logic       o_rd_gnt_a,
  output logic       o_rd_gnt_b,
  output logic [7:0] o_ram_raddr
);

  localparam logic [7:0]  ANT_VALID = 8'((16'd1 << NUM_ANT) - 16'd1);
  localparam logic [11:0] FDIV_LAST = 12'(FRAM_DIV - 1);
  localparam logic [7:0]  GCLK_LAST = 8'(GUARD_CLK - 1);

  pd_state_e   state, nxt_state;
  logic [11:0] fcnt, nxt_fcnt;
  logic [7:0]  gcnt, nxt_gcnt;
  logic [7:0]  ant_mask, nxt_mask;
  logic [2:0]  nxt_ant;
  logic        nxt_err, nxt_done, nxt_seq_end;
  logic [3:0]  first_ant, next_ant;

  always_comb begin
    nxt_state   = state;
    nxt_fcnt    = fcnt;
    nxt_gcnt    = gcnt;
    nxt_mask    = ant_mask;
    nxt_ant     = o_ant_sel;
    nxt_err     = o_err;
    nxt_done    = 1'b0;
    nxt_seq_end = 1'b0;
    first_ant   = find_ant(i_ant_mask & ANT_VALID, 0);
    next_ant    = find_ant(ant_mask, 32'(o_ant_sel) + 32'd1);

    if (state == ST_IDLE) begin
      // Abort coinciding with start in IDLE swallows the start entirely.
      if (i_start && !i_abort) begin
        if (first_ant[3]) begin
          nxt_mask  = i_ant_mask & ANT_VALID;
          nxt_ant   = first_ant[2:0];
          nxt_err   = 1'b0;
          nxt_state = ST_ARM;
        end else begin
          nxt_err = 1'b1;
        end
      end
    end else begin
      if (i_start) nxt_err = 1'b1;
      if (i_abort) begin
        nxt_state   = ST_IDLE;
        nxt_seq_end = 1'b1;
      end else begin
        case (state)
          ST_ARM: begin
            if (i_fram_hd) begin
              nxt_state = ST_MEAS;
              nxt_fcnt  = '0;
            end
          end
          ST_MEAS: begin
            if (i_fram_hd) begin
              if (fcnt == FDIV_LAST) begin
                nxt_state = ST_GUARD;
                nxt_gcnt  = '0;
              end else begin
                nxt_fcnt = fcnt + 12'd1;
              end
            end
          end
          ST_GUARD: begin
            if (gcnt == GCLK_LAST) begin
              nxt_state = ST_NEXT;
              nxt_done  = 1'b1;
            end else begin
              nxt_gcnt = gcnt + 8'd1;
            end
          end
          ST_NEXT: begin
            if (next_ant[3]) begin
              nxt_ant   = next_ant[2:0];
              nxt_state = ST_ARM;
            end else begin
              nxt_state   = ST_IDLE;
              nxt_seq_end = 1'b1;
            end
          end
          default: nxt_state = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_245 or negedge asy_rst_n) begin
    if (!asy_rst_n) begin
      state     <= ST_IDLE;
      fcnt      <= '0;
      gcnt      <= '0;
      ant_mask  <= '0;
      o_ant_sel <= '0;
      o_pd_trig <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_seq_end <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state     <= nxt_state;
      fcnt      <= nxt_fcnt;
      gcnt      <= nxt_gcnt;
      ant_mask  <= nxt_mask;
      o_ant_sel <= nxt_ant;
      o_pd_trig <= (nxt_state == ST_MEAS);
      o_busy    <= (nxt_state != ST_IDLE);
      o_done    <= nxt_done;
      o_seq_end <= nxt_seq_end;
      o_err     <= nxt_err;
    end
  end

  lte_ul_pd_rd_arb u_rd_arb (
    .clk_245     (clk_245),
    .asy_rst_n   (asy_rst_n),
    .i_rd_req_a  (i_rd_req_a),
    .i_rd_req_b  (i_rd_req_b),
    .i_rd_addr_a (i_rd_addr_a),
    .i_rd_addr_b (i_rd_addr_b),
    .o_rd_gnt_a  (o_rd_gnt_a),
    .o_rd_gnt_b  (o_rd_gnt_b),
    .o_ram_raddr (o_ram_raddr)
  );

endmodule

// File: tb/tb_lte_ul_pd_sched.sv
// Scoreboard bench for lte_ul_pd_sched: stimulus tasks queue expected windows,
// pulses and grants; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_lte_ul_pd_sched;

  localparam int unsigned NA = 8;
  localparam int unsigned FD = 3;
  localparam int unsigned GC = 4;

  logic       clk_245 = 1'b0;
  logic       asy_rst_n = 1'b0;
  logic       i_fram_hd = 1'b0, i_start = 1'b0, i_abort = 1'b0;
  logic [7:0] i_ant_mask = '0;
  logic [2:0] o_ant_sel;
  logic       o_pd_trig, o_busy, o_done, o_seq_end, o_err;
  logic       i_rd_req_a = 1'b0, i_rd_req_b = 1'b0;
  logic [7:0] i_rd_addr_a = '0, i_rd_addr_b = '0;
  logic       o_rd_gnt_a, o_rd_gnt_b;
  logic [7:0] o_ram_raddr;

  lte_ul_pd_sched #(.NUM_ANT(NA), .FRAM_DIV(FD), .GUARD_CLK(GC)) dut (
    .clk_245(clk_245), .asy_rst_n(asy_rst_n), .i_fram_hd(i_fram_hd),
    .i_start(i_start), .i_abort(i_abort), .i_ant_mask(i_ant_mask),
    .o_ant_sel(o_ant_sel), .o_pd_trig(o_pd_trig), .o_busy(o_busy),
    .o_done(o_done), .o_seq_end(o_seq_end), .o_err(o_err),
    .i_rd_req_a(i_rd_req_a), .i_rd_req_b(i_rd_req_b),
    .i_rd_addr_a(i_rd_addr_a), .i_rd_addr_b(i_rd_addr_b),
    .o_rd_gnt_a(o_rd_gnt_a), .o_rd_gnt_b(o_rd_gnt_b), .o_ram_raddr(o_ram_raddr)
  );

  always #5 clk_245 = ~clk_245;

  typedef struct { logic [2:0] ant; int unsigned frames; } win_t;
  typedef struct { int unsigned cyc; logic [1:0] gnt; logic [7:0] addr; } arb_t;

  win_t       win_q[$];
  logic [2:0] done_q[$];
  logic       seq_q[$];
  arb_t       arb_q[$];

  int unsigned n_chk = 0, n_pass = 0, cyc = 0;

  always @(posedge clk_245) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic miss(input string name);
    n_chk++;
    $display("FAIL %s: got event/timeout, expected none at %0t", name, $time);
  endtask

  // Frame-header source with a randomized period (8..15 cycles).
  initial begin
    forever begin
      repeat ($urandom_range(7, 14)) @(posedge clk_245);
      #1 i_fram_hd = 1'b1;
      @(posedge clk_245);
      #1 i_fram_hd = 1'b0;
    end
  end

  // Monitor: compares everything the DUT presents against queued expectations.
  initial begin : monitor
    logic        prev_trig;
    int unsigned frames, gmon;
    logic [2:0]  ant_rise;
    logic [7:0]  exp_raddr;
    arb_t        a;
    win_t        w;
    logic [2:0]  d;
    logic        e;
    prev_trig = 1'b0; frames = 0; gmon = 0; ant_rise = '0; exp_raddr = '0;
    forever begin
      @(negedge clk_245);
      if (!asy_rst_n) begin
        prev_trig = 1'b0;
        exp_raddr = '0;
      end else begin
        check("ram_raddr", 32'(o_ram_raddr), 32'(exp_raddr));
        if (o_rd_gnt_a || o_rd_gnt_b) begin
          if (arb_q.size() == 0) miss("grant_unexpected");
          else begin
            a = arb_q.pop_front();
            check("grant_cycle", cyc, a.cyc);
            check("grant_side", 32'({o_rd_gnt_a, o_rd_gnt_b}), 32'(a.gnt));
            exp_raddr = a.addr;
          end
        end
        if (o_pd_trig && !prev_trig) begin
          frames   = 0;
          ant_rise = o_ant_sel;
          check("busy_in_window", 32'(o_busy), 32'd1);
        end
        if (o_pd_trig && i_fram_hd) frames++;
        if (!o_pd_trig && prev_trig) begin
          gmon = 0;
          if (win_q.size() == 0) miss("window_unexpected");
          else begin
            w = win_q.pop_front();
            check("window_ant_rise", 32'(ant_rise), 32'(w.ant));
            check("window_ant_fall", 32'(o_ant_sel), 32'(w.ant));
            check("window_frames", frames, w.frames);
          end
        end else begin
          gmon++;
        end
        if (o_done) begin
          if (done_q.size() == 0) miss("done_unexpected");
          else begin
            d = done_q.pop_front();
            check("done_ant", 32'(o_ant_sel), 32'(d));
            check("done_guard_cycles", gmon, GC);
          end
        end
        if (o_seq_end) begin
          if (seq_q.size() == 0) miss("seq_end_unexpected");
          else begin
            e = seq_q.pop_front();
            check("seq_end_trig", 32'(o_pd_trig), 32'd0);
            check("seq_end_busy", 32'(o_busy), 32'd0);
            check("seq_end_err", 32'(o_err), 32'(e));
          end
        end
        prev_trig = o_pd_trig;
      end
    end
  end

  // Reference arbiter: single requester wins; with both, the side not granted last.
  task automatic run_arb();
    logic last_b = 1'b1;
    for (int n = 0; n < 204; n++) begin
      logic ra, rb;
      logic [7:0] aa, ab;
      arb_t e;
      if (n < 4) begin
        ra = 1'b1; rb = 1'b1; aa = 8'h10; ab = 8'h20;
      end else begin
        ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
        aa = 8'($urandom); ab = 8'($urandom);
      end
      @(posedge clk_245);
      #1;
      i_rd_req_a = ra; i_rd_req_b = rb; i_rd_addr_a = aa; i_rd_addr_b = ab;
      if (ra || rb) begin
        e.cyc = cyc;
        if (ra && rb) e.gnt = last_b ? 2'b10 : 2'b01;
        else          e.gnt = ra ? 2'b10 : 2'b01;
        e.addr = e.gnt[1] ? aa : ab;
        last_b = e.gnt[0];
        arb_q.push_back(e);
      end
    end
    @(posedge clk_245);
    #1 i_rd_req_a = 1'b0; i_rd_req_b = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] m);
    @(posedge clk_245);
    #1 i_start = 1'b1; i_ant_mask = m;
    @(posedge clk_245);
    #1 i_start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk_245);
    #1 i_abort = 1'b1;
    @(posedge clk_245);
    #1 i_abort = 1'b0;
  endtask

  task automatic wait_trig(input logic lvl);
    for (int i = 0; i < 3000; i++) begin
      if (o_pd_trig == lvl) return;
      @(posedge clk_245);
      #1;
    end
    miss("timeout_pd_trig");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      if (!o_busy) return;
      @(posedge clk_245);
      #1;
    end
    miss("timeout_busy");
  endtask

  task automatic wait_hd();
    logic got;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_245);
      got = i_fram_hd;
      #1;
      if (got) return;
    end
    miss("timeout_fram_hd");
  endtask

  // Full sequence: one FD-frame window per enabled antenna in ascending order.
  task automatic full_seq(input logic [7:0] m, input logic busy_start);
    win_t w;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        w.ant = 3'(i); w.frames = FD;
        win_q.push_back(w);
        done_q.push_back(3'(i));
      end
    end
    seq_q.push_back(busy_start);
    pulse_start(m);
    if (busy_start) begin
      wait_trig(1'b1);
      wait_hd();
      pulse_start(8'($urandom));
    end
    wait_idle();
  endtask

  // Abort in ARM (phase 0) or after phase-1 frame headers inside the window.
  task automatic abort_seq(input logic [7:0] m, input int unsigned phase);
    logic [2:0] first = '0;
    win_t w;
    for (int i = 7; i >= 0; i--) if (m[i]) first = 3'(i);
    seq_q.push_back(1'b0);
    pulse_start(m);
    if (phase > 0) begin
      wait_trig(1'b1);
      repeat (phase - 1) wait_hd();
      w.ant = first; w.frames = phase - 1;
      win_q.push_back(w);
    end
    #0 i_abort = 1'b1;
    @(posedge clk_245);
    #1 i_abort = 1'b0;
    wait_idle();
  endtask

  task automatic err_case();
    pulse_start(8'h00);
    check("empty_mask_err", 32'(o_err), 32'd1);
    check("empty_mask_busy", 32'(o_busy), 32'd0);
    @(posedge clk_245);
    #1 i_abort = 1'b1; i_start = 1'b1; i_ant_mask = 8'h01;
    @(posedge clk_245);
    #1 i_abort = 1'b0; i_start = 1'b0;
    check("abort_start_err", 32'(o_err), 32'd1);
    check("abort_start_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [2:0] rant;
    win_t w;
    repeat (3) @(posedge clk_245);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_trig", 32'(o_pd_trig), 32'd0);
    check("rst_ant_sel", 32'(o_ant_sel), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_seq_end", 32'(o_seq_end), 32'd0);
    check("rst_raddr", 32'(o_ram_raddr), 32'd0);
    asy_rst_n = 1'b1;

    fork
      run_arb();
      begin
        full_seq(8'h05, 1'b0);
        err_case();
        full_seq(8'h01, 1'b0);
        abort_seq(8'h06, 2);
        full_seq(8'h80, 1'b1);
        for (int it = 0; it < 8; it++) begin
          case ($urandom_range(0, 3))
            0: full_seq(8'($urandom_range(1, 255)), 1'b0);
            1: full_seq(8'($urandom_range(1, 255)), 1'b1);
            2: abort_seq(8'($urandom_range(1, 255)), $urandom_range(0, 2));
            default: err_case();
          endcase
        end
      end
    join

    // Reset in GUARD: outputs clear at once and no pulses follow.
    rant = 3'($urandom_range(1, 7));
    w.ant = rant; w.frames = FD;
    win_q.push_back(w);
    pulse_start(8'(8'd1 << rant));
    wait_trig(1'b1);
    wait_trig(1'b0);
    @(posedge clk_245);
    #3 asy_rst_n = 1'b0;
    #1;
    check("grst_busy", 32'(o_busy), 32'd0);
    check("grst_ant_sel", 32'(o_ant_sel), 32'd0);
    check("grst_trig", 32'(o_pd_trig), 32'd0);
    check("grst_done", 32'(o_done), 32'd0);
    check("grst_err", 32'(o_err), 32'd0);
    check("grst_raddr", 32'(o_ram_raddr), 32'd0);
    repeat (3) @(posedge clk_245);
    #1 asy_rst_n = 1'b1;
    repeat (3 * GC) @(posedge clk_245);
    #1;
    check("post_rst_busy", 32'(o_busy), 32'd0);
    check("post_rst_trig", 32'(o_pd_trig), 32'd0);

    check("win_q_left", win_q.size(), 0);
    check("done_q_left", done_q.size(), 0);
    check("seq_q_left", seq_q.size(), 0);
    check("arb_q_left", arb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lte_ul_pd_sched.md
LTE_UL_PD_SCHED -- requirements
Module: lte_ul_pd_sched

Interface
REQ-001 Parameter NUM_ANT, default 8, number of antennas sequenced (1..8).
REQ-002 Parameter FRAM_DIV, default 300, 5 ms frames per measurement window (1..4095).
REQ-003 Parameter GUARD_CLK, default 16, clk_245 cycles from window end to o_done (1..255).
REQ-004 clk_245  in  1  sole clock, 245.76 MHz.
REQ-005 asy_rst_n  in  1  asynchronous active-low reset, deasserted synchronously to clk_245.
REQ-006 i_fram_hd  in  1  one-cycle 5 ms frame-header pulse.
REQ-007 i_start  in  1  one-cycle software start pulse.
REQ-008 i_abort  in  1  one-cycle software abort pulse.
REQ-009 i_ant_mask  in  8  enabled antennas, sampled on accepted start.
REQ-010 o_ant_sel  out  3  antenna routed to power detector.
REQ-011 o_pd_trig  out  1  trigger level to power detector, high for whole window.
REQ-012 o_busy  out  1  sequence in progress.
REQ-013 o_done  out  1  one-cycle pulse per finished antenna window.
REQ-014 o_seq_end  out  1  one-cycle pulse when all masked antennas finished or abort completes.
REQ-015 o_err  out  1  sticky: start ignored while busy or empty mask; cleared by next accepted start.
REQ-016 i_rd_req_a / i_rd_req_b  in  1 each  read-port requests (A = APB, B = AGC).
REQ-017 i_rd_addr_a / i_rd_addr_b  in  8 each  requested RAM read address.
REQ-018 o_rd_gnt_a / o_rd_gnt_b  out  1 each  one-cycle grant.
REQ-019 o_ram_raddr  out  8  address to power-detect RAM read port.

Function
REQ-020 FSM states IDLE, ARM, MEAS, GUARD, NEXT; reset state IDLE.
REQ-021 IDLE: start with nonzero mask latches mask, selects lowest set bit index <NUM_ANT, goes ARM; otherwise stays IDLE and sets o_err.
REQ-022 ARM: o_pd_trig low; on i_fram_hd goes MEAS, clears frame counter to 0, raises o_pd_trig next cycle.
REQ-023 MEAS: frame counter increments on each i_fram_hd; at count FRAM_DIV-1 with i_fram_hd goes GUARD, o_pd_trig low.
REQ-024 GUARD: counts GUARD_CLK cycles, then pulses o_done and goes NEXT.
REQ-025 NEXT: selects next higher set mask bit; if found goes ARM (one cycle), else pulses o_seq_end, goes IDLE.
REQ-026 o_ant_sel changes only in IDLE->ARM and NEXT->ARM; stable through ARM/MEAS/GUARD.
REQ-027 o_busy high in all states except IDLE.
REQ-028 Start while busy ignored, sets o_err; sequence unaffected.
REQ-029 Abort in any non-IDLE state: next cycle o_pd_trig low, state IDLE, o_seq_end pulse, no o_done.
REQ-030 Abort and start same cycle in IDLE: abort wins, start ignored, o_err unchanged.
REQ-031 i_fram_hd coincident with GUARD or NEXT ignored.
REQ-032 Read arbiter: round-robin between A and B; single request granted same cycle; both requesting: grant side not granted last, initial priority A.
REQ-033 o_ram_raddr registered: equals granted address one cycle after grant; holds last value when no grant.
REQ-034 Grant is a single-cycle pulse per request cycle; requester drops req after grant; held req re-arbitrates each cycle.
REQ-035 Arbiter independent of FSM; operates in all states.

Reset
REQ-036 Asynchronous assertion: state IDLE, counters 0, mask 0, o_ant_sel 0, o_pd_trig 0, o_busy 0, o_done 0, o_seq_end 0, o_err 0, grants 0, o_ram_raddr 0, RR pointer A.
REQ-037 Reset mid-sequence aborts silently, no o_done/o_seq_end pulse.

Structure
REQ-038 Shared package holds FSM state encoding, NUM_ANT/FRAM_DIV/GUARD_CLK defaults, 5 ms frame constant.
REQ-039 Sub-module lte_ul_pd_rd_arb implements REQ-032..034; FSM and counters in top.

Verification
REQ-040 Mask 0x05, FRAM_DIV=3, start -> ant 0 then ant 2 windows, each o_pd_trig high 3 frames, 2 o_done, 1 o_seq_end, o_busy falls after.
REQ-041 Start with mask 0x00 -> stays IDLE, o_err=1; next start mask 0x01 -> o_err=0.
REQ-042 Abort during MEAS frame 1 -> o_pd_trig low next cycle, o_seq_end pulse, no o_done.
REQ-043 Start during MEAS -> o_err=1, window length unchanged.
REQ-044 A and B requesting 4 cycles (addr 0x10/0x20) -> grants A,B,A,B; o_ram_raddr 0x10,0x20,0x10,0x20 one cycle later.
REQ-045 asy_rst_n low in GUARD -> all outputs 0 immediately, IDLE after release, no pulses.
